muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 35 +++
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request/response bundle between the execute stage and the
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic [2:0]           op_i;
    logic                 annul_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic [WIDTH-1:0]     hi_i;
    logic [WIDTH-1:0]     lo_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;
    logic                 div_by_zero_o;

    modport master (
        output start_i, op_i, annul_i, opdata1_i, opdata2_i, hi_i, lo_i,
        input  result_o, ready_o, busy_o, div_by_zero_o
    );

    modport slave (
        input  start_i, op_i, annul_i, opdata1_i, opdata2_i, hi_i, lo_i,
        output result_o, ready_o, busy_o, div_by_zero_o
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle multiply / multiply-accumulate / restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    muldiv_unit_if.slave bus
);
    localparam int c_cnt_w = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        ACC  = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t               r_state;
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_dbz;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_div;
    logic                 r_qneg;
    logic                 r_rneg;
    logic [c_cnt_w-1:0]   r_cnt;

    // Operand magnitudes are taken at accept so the divider only sees unsigned data
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_is_div_in;

    assign w_a_neg     = ~bus.op_i[0] & bus.opdata1_i[WIDTH-1];
    assign w_b_neg     = ~bus.op_i[0] & bus.opdata2_i[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign w_b_mag     = w_b_neg ? -bus.opdata2_i : bus.opdata2_i;
    assign w_is_div_in = bus.op_i[2] & bus.op_i[1];

    logic [2*WIDTH-1:0]   w_ext1;
    logic [2*WIDTH-1:0]   w_ext2;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_acc;

    assign w_ext1 = r_op[0] ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{r_a[WIDTH-1]}}, r_a};
    assign w_ext2 = r_op[0] ? {{WIDTH{1'b0}}, r_b} : {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod = w_ext1 * w_ext2;
    assign w_acc  = r_op[2] ? ({r_hi, r_lo} - r_prod) : ({r_hi, r_lo} + r_prod);

    // One restoring step: shift in the next dividend bit, keep the difference if non-negative
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_diff;
    logic                 w_qbit;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_quot_next;
    logic [2*WIDTH-1:0]   w_div_res;

    assign w_shift     = {r_rem, r_quot[WIDTH-1]};
    assign w_diff      = w_shift - {1'b0, r_div};
    assign w_qbit      = ~w_diff[WIDTH];
    assign w_rem_next  = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], w_qbit};
    assign w_div_res   = {(r_rneg ? -w_rem_next : w_rem_next),
                          (r_qneg ? -w_quot_next : w_quot_next)};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_dbz    <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_prod   <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_div    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_dbz   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start_i && !bus.annul_i) begin
                        r_op   <= bus.op_i;
                        r_a    <= bus.opdata1_i;
                        r_b    <= bus.opdata2_i;
                        r_hi   <= bus.hi_i;
                        r_lo   <= bus.lo_i;
                        r_rem  <= '0;
                        r_quot <= w_a_mag;
                        r_div  <= w_b_mag;
                        r_qneg <= w_a_neg ^ w_b_neg;
                        r_rneg <= w_a_neg;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (w_is_div_in && (bus.opdata2_i == '0)) begin
                            r_state  <= DONE;
                            r_ready  <= 1'b1;
                            r_dbz    <= 1'b1;
                            r_result <= '0;
                        end else if (w_is_div_in) begin
                            r_state <= DIV;
                        end else begin
                            r_state <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (bus.annul_i) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_op[2:1] == 2'b00) begin
                        r_result <= w_prod;
                        r_ready  <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_prod  <= w_prod;
                        r_state <= ACC;
                    end
                end
                ACC: begin
                    if (bus.annul_i) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_result <= w_acc;
                        r_ready  <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DIV: begin
                    if (bus.annul_i) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_rem  <= w_rem_next;
                        r_quot <= w_quot_next;
                        if (r_cnt == c_cnt_w'(WIDTH - 1)) begin
                            r_cnt    <= '0;
                            r_result <= w_div_res;
                            r_ready  <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result_o      = r_result;
    assign bus.ready_o       = r_ready;
    assign bus.busy_o        = r_busy;
    assign bus.div_by_zero_o = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Randomised bench for muldiv_unit with an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) bus32();
    muldiv_unit_if #(.WIDTH(8))  bus8();

    muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: result of an op straight from the arithmetic definitions
    function automatic logic [63:0] exp_calc(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = op[0] ? ua * ub : sa * sb;
        case (op[2:1])
            2'b00:   return p;
            2'b01:   return {h, l} + p;
            2'b10:   return {h, l} - p;
            default: begin
                if (b == 32'd0) return 64'd0;
                if (op[0]) begin q = ua / ub; r = ua % ub; end
                else       begin q = sa / sb; r = sa % sb; end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
        case (op[2:1])
            2'b00:   return 2;
            2'b11:   return (b == 32'd0) ? 1 : 33;
            default: return 3;
        endcase
    endfunction

    // Cycle model: countdown to the result cycle, abort on annul, reset wins
    bit          m_busy = 1'b0, m_ready = 1'b0, m_dbz = 1'b0, m_pend_dbz = 1'b0;
    int          m_left = 0;
    logic [63:0] m_result = '0, m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_ready = 1'b0; m_dbz = 1'b0; m_result = '0;
        end else if (m_ready) begin
            m_busy = 1'b0; m_ready = 1'b0; m_dbz = 1'b0;
        end else if (m_busy) begin
            if (bus32.annul_i) m_busy = 1'b0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_ready = 1'b1; m_result = m_pend; m_dbz = m_pend_dbz;
                end
            end
        end else if (bus32.start_i && !bus32.annul_i) begin
            m_busy     = 1'b1;
            m_pend     = exp_calc(bus32.op_i, bus32.opdata1_i, bus32.opdata2_i,
                                  bus32.hi_i, bus32.lo_i);
            m_pend_dbz = (bus32.op_i[2:1] == 2'b11) && (bus32.opdata2_i == 32'd0);
            m_left     = exp_lat(bus32.op_i, bus32.opdata2_i) - 1;
            if (m_left == 0) begin
                m_ready = 1'b1; m_result = m_pend; m_dbz = m_pend_dbz;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 64'(bus32.ready_o), 64'(m_ready));
            chk("busy",  64'(bus32.busy_o),  64'(m_busy));
            chk("dbz",   64'(bus32.div_by_zero_o), 64'(m_dbz));
            chk("result", bus32.result_o, m_result);
        end
    end

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom());
        endcase
    endfunction

    // Called on a negedge in IDLE; returns on the negedge of the following IDLE cycle
    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                         input logic [63:0] exp, input int lat, input logic dbz);
        int cyc;
        bus32.start_i = 1'b1; bus32.op_i = op;
        bus32.opdata1_i = a; bus32.opdata2_i = b; bus32.hi_i = h; bus32.lo_i = l;
        @(negedge clk);
        bus32.start_i = 1'b0;
        bus32.opdata1_i = $urandom(); bus32.opdata2_i = $urandom();
        bus32.hi_i = $urandom(); bus32.lo_i = $urandom();
        cyc = 1;
        while (!bus32.ready_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_lat"}, 64'(cyc), 64'(lat));
        chk({nm, "_res"}, bus32.result_o, exp);
        chk({nm, "_dbz"}, 64'(bus32.div_by_zero_o), 64'(dbz));
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        bus32.start_i = 1'b0; bus32.op_i = '0; bus32.annul_i = 1'b0;
        bus32.opdata1_i = '0; bus32.opdata2_i = '0; bus32.hi_i = '0; bus32.lo_i = '0;
        bus8.start_i = 1'b0; bus8.op_i = '0; bus8.annul_i = 1'b0;
        bus8.opdata1_i = '0; bus8.opdata2_i = '0; bus8.hi_i = '0; bus8.lo_i = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_result", bus32.result_o, 64'd0);
        chk("rst_busy", 64'(bus32.busy_o), 64'd0);
        chk("rst8_result", 64'(bus8.result_o), 64'd0);
        rst = 1'b0;

        do_op("mult",  3'b000, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFF1, 2, 1'b0);
        do_op("multu", 3'b001, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 64'h0000_0004_FFFF_FFF1, 2, 1'b0);
        do_op("maddu", 3'b011, 32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF, 64'h0000_0002_0000_0000, 3, 1'b0);
        do_op("msub",  3'b100, 32'd2, 32'd3, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFA, 3, 1'b0);
        do_op("div",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b0);
        do_op("divu",  3'b111, 32'd100, 32'd7, 32'd0, 32'd0, 64'h0000_0002_0000_000E, 33, 1'b0);
        do_op("divu0", 3'b111, 32'd5, 32'd0, 32'd0, 32'd0, 64'd0, 1, 1'b1);
        do_op("divmin", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'h0000_0000_8000_0000, 33, 1'b0);
        do_op("mult12", 3'b000, 32'd3, 32'd4, 32'd0, 32'd0, 64'd12, 2, 1'b0);

        // Annul a divide mid-flight, then start a multiply in the very next cycle
        bus32.start_i = 1'b1; bus32.op_i = 3'b110;
        bus32.opdata1_i = 32'hFFFF_FFF9; bus32.opdata2_i = 32'd2;
        @(negedge clk);
        bus32.start_i = 1'b0;
        repeat (4) @(negedge clk);
        bus32.annul_i = 1'b1;
        @(negedge clk);
        bus32.annul_i = 1'b0;
        chk("annul_busy", 64'(bus32.busy_o), 64'd0);
        chk("annul_keep", bus32.result_o, 64'd12);
        do_op("post_annul", 3'b001, 32'd6, 32'd7, 32'd0, 32'd0, 64'd42, 2, 1'b0);

        // Reset in the middle of a divide
        bus32.start_i = 1'b1; bus32.op_i = 3'b110;
        bus32.opdata1_i = 32'd1000; bus32.opdata2_i = 32'd3;
        @(negedge clk);
        bus32.start_i = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(bus32.busy_o), 64'd0);
        chk("midrst_result", bus32.result_o, 64'd0);
        do_op("post_rst", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'd1, 2, 1'b0);

        // Narrow instance divide
        bus8.start_i = 1'b1; bus8.op_i = 3'b110;
        bus8.opdata1_i = 8'hF9; bus8.opdata2_i = 8'h02;
        @(negedge clk);
        bus8.start_i = 1'b0;
        cyc = 1;
        while (!bus8.ready_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("div8_lat", 64'(cyc), 64'd9);
        chk("div8_res", 64'(bus8.result_o), 64'hFFFD);
        @(negedge clk);

        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom_range(0, 299) == 0);
            bus32.start_i = 1'($urandom_range(0, 1));
            bus32.annul_i = ($urandom_range(0, 39) == 0);
            bus32.op_i    = 3'($urandom_range(0, 7));
            bus32.opdata1_i = rnd_opnd();
            bus32.opdata2_i = rnd_opnd();
            bus32.hi_i    = rnd_opnd();
            bus32.lo_i    = rnd_opnd();
            @(negedge clk);
        end
        rst = 1'b0; bus32.start_i = 1'b0; bus32.annul_i = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
